pps_tracker: RTL
================

Name: pps_tracker

Overview:
- Multi-source 1PPS tracker and disciplined PPS generator; successor to the single-input PPS receiver.
- Selects one of C_NUM_SOURCES external PPS inputs and synchronises it into the core clock domain.
- Filters ±C_WINDOW tick jitter with saturating advance/late counters, detects missing pulses, and free-runs (holdover) through outages.
- Reports lock state, phase and signed phase error to fabric/register bank.

Parameters:
- C_CLOCK_FREQUENCY, 125000000: core clock Hz. Defines one second F. W = $clog2(F-1).
- C_NUM_SOURCES, 2: number of PPS inputs, 1..8.
- C_WINDOW, 1: in-window tolerance in ticks, 1..F/4-1.
- C_FILTER_BITS, 4: width of the advance/late filter counters.
- C_LOCK_COUNT, 3: consecutive in-window edges required for ACQUIRE->LOCKED.
- C_HOLDOVER_MAX, 10: consecutive misses tolerated in HOLDOVER before NO_SIGNAL.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- pps_in  in  C_NUM_SOURCES  async external PPS inputs
- pps_sel  in  $clog2(C_NUM_SOURCES) (min 1)  source select, quasi-static
- pps_out  out  1  one-cycle internal PPS pulse
- pps_state  out  2  0=NO_SIGNAL, 1=ACQUIRE, 2=LOCKED, 3=HOLDOVER
- pps_phase  out  W  current reference phase (last_pha)
- pps_err  out  W+1  signed error of last accepted edge
- pps_err_valid  out  1  one-cycle strobe with pps_err

Behaviour:
- Single clock clk. Reset rst is synchronous, active-high.
- Reset values: pps_out=0, pps_state=NO_SIGNAL, pps_phase=0, pps_err=0, pps_err_valid=0. All counters and last_pha=0.
- Synchroniser: each pps_in bit passes a 2-FF ASYNC_REG synchroniser plus a delay FF; the rising-edge detect runs on every source continuously.
- Edge: edge = rising edge of the selected source. An out-of-range pps_sel gives no edges.
- free_counter: 0..F-1, wraps at F-1, cleared by rst. Never reloaded; alignment lives in last_pha.
- Error: d = (free_counter - last_pha) mod F. e = d if d <= F/2, else d - F. On edge: pps_err <= e and pps_err_valid=1 on the next cycle.
- match: e=0. adv: -C_WINDOW <= e < 0. late: 0 < e <= C_WINDOW. out: |e| > C_WINDOW.
- Filter on edge:
  - match: decrement both nonzero counters.
  - adv: late_cnt-- (if >0), adv_cnt++. If adv_cnt was all-ones, last_pha <= free_counter and both counters clear.
  - late: mirror of adv.
  - out: last_pha <= free_counter, clear both counters, lock_cnt=0, miss_cnt=0, state -> ACQUIRE.
- Miss detect:
  - deadline = (last_pha + C_WINDOW + 1) mod F.
  - edge_seen sets on any edge and clears when free_counter == deadline.
  - Reaching the deadline with edge_seen=0 is a miss.
  - Edge and deadline in the same cycle: the edge wins (it is "out" and realigns), no miss.
- State machine (in-window = match/adv/late):
  - NO_SIGNAL: any edge -> ACQUIRE (realign as "out"). Misses ignored.
  - ACQUIRE: in-window edge -> lock_cnt++; reaching C_LOCK_COUNT -> LOCKED. Miss -> lock_cnt=0, stay. Out -> realign, stay.
  - LOCKED: miss -> HOLDOVER, miss_cnt=1. Out -> ACQUIRE.
  - HOLDOVER: in-window edge -> LOCKED, miss_cnt=0. Miss -> miss_cnt++; exceeding C_HOLDOVER_MAX -> NO_SIGNAL. Out -> ACQUIRE.
- Source switch: a pps_sel change (registered compare) clears adv_cnt, late_cnt and lock_cnt. LOCKED -> HOLDOVER (miss_cnt=0); other states are unchanged. last_pha is kept.
- pps_out: registered (free_counter == last_pha), so it fires one cycle after the match, in every state including NO_SIGNAL (free-run).
- pps_phase: registered last_pha, one-cycle latency.
- Reset mid-second: everything returns to reset values; the next edge after reset realigns.

Test Plan:
- Sim with F=1000, C_WINDOW=1, C_LOCK_COUNT=3, C_HOLDOVER_MAX=2.
- Source 0, edge every 1000 cycles, first at free_counter=200 -> state ACQUIRE after the 1st edge, LOCKED after the 4th. pps_phase=200. pps_out 1 cycle after each free_counter==200. pps_err=0.
- Locked at 200, then 16 edges at 199 -> pps_err=-1 each time. last_pha stays 200 through the 15th, becomes 199 on the 16th. Alternating 199/201 never moves last_pha.
- Locked, edges stop -> HOLDOVER at free_counter=202 of the first missing second. pps_out keeps firing at 200. NO_SIGNAL after the 3rd miss. An edge at 201 in HOLDOVER returns to LOCKED.
- Locked, one edge at 700 -> pps_err=+500 (e=500 <= F/2), state ACQUIRE, last_pha=700, counters cleared. An edge at 699 -> pps_err=-501 equivalent wrap check: e=-1 from the new phase.
- Locked on source 0, switch pps_sel to 1 (source 1 edge at 200) -> HOLDOVER then LOCKED on the first in-window edge. Out-of-range pps_sel -> misses -> NO_SIGNAL.
- rst asserted mid-ACQUIRE -> all outputs 0 and NO_SIGNAL next cycle. The next edge at 450 -> ACQUIRE with pps_phase=450.

Source files
------------

// File: rtl/pps_tracker.sv
// Multi-source 1PPS tracker: synchronises the selected PPS input, filters jitter
// against a free-running phase reference, detects misses and reports lock state.
module pps_tracker #(
    parameter int C_CLOCK_FREQUENCY = 125000000,
    parameter int C_NUM_SOURCES     = 2,
    parameter int C_WINDOW          = 1,
    parameter int C_FILTER_BITS     = 4,
    parameter int C_LOCK_COUNT      = 3,
    parameter int C_HOLDOVER_MAX    = 10,
    localparam int W     = $clog2(C_CLOCK_FREQUENCY - 1),
    localparam int SEL_W = (C_NUM_SOURCES > 1) ? $clog2(C_NUM_SOURCES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [C_NUM_SOURCES-1:0] pps_in,
    input  logic [SEL_W-1:0]         pps_sel,
    output logic                     pps_out,
    output logic [1:0]               pps_state,
    output logic [W-1:0]             pps_phase,
    output logic signed [W:0]        pps_err,
    output logic                     pps_err_valid
);

    localparam int LK_W = $clog2(C_LOCK_COUNT + 1);
    localparam int MS_W = $clog2(C_HOLDOVER_MAX + 2);
    localparam int FB   = C_FILTER_BITS;
    localparam logic [W:0]        F_W1   = (W+1)'(C_CLOCK_FREQUENCY);
    localparam logic [W:0]        HALF   = (W+1)'(C_CLOCK_FREQUENCY / 2);
    localparam logic [W:0]        DL_OFF = (W+1)'(C_WINDOW + 1);
    localparam logic signed [W:0] WIN_S  = (W+1)'(C_WINDOW);

    typedef enum logic [1:0] {
        ST_NO_SIGNAL = 2'd0,
        ST_ACQUIRE   = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_HOLDOVER  = 2'd3
    } state_t;

    function automatic logic [FB-1:0] sat_dec(input logic [FB-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    (* ASYNC_REG = "TRUE" *) logic [C_NUM_SOURCES-1:0] sync1_q;
    (* ASYNC_REG = "TRUE" *) logic [C_NUM_SOURCES-1:0] sync2_q;
    logic [C_NUM_SOURCES-1:0] sync3_q;
    logic [C_NUM_SOURCES-1:0] rise;
    logic [SEL_W-1:0]         sel_q;
    logic                     sel_change;
    logic                     pps_edge;

    logic [W-1:0]        fc_q, fc_d;
    logic [W-1:0]        lp_q, lp_d;
    logic [FB-1:0]       adv_q, adv_d, late_q, late_d;
    logic [LK_W-1:0]     lock_q, lock_d;
    logic [MS_W-1:0]     miss_q, miss_d;
    logic                edge_seen_q, edge_seen_d;
    state_t              state_q, state_d;
    logic                pps_out_q;
    logic [W-1:0]        phase_q;
    logic signed [W:0]   err_q;
    logic                err_vld_q;

    logic [W:0]          d, dl_sum, deadline;
    logic signed [W:0]   e;
    logic                is_match, is_adv, is_late, in_win, dl_hit, miss;

    // Input synchronisers run on every source so a switch sees settled history
    always_ff @(posedge clk) begin
        sync1_q <= pps_in;
        sync2_q <= sync1_q;
        sync3_q <= sync2_q;
        sel_q   <= pps_sel;
    end

    assign rise       = sync2_q & ~sync3_q;
    assign sel_change = (pps_sel != sel_q);

    always_comb begin
        pps_edge = 1'b0;
        for (int i = 0; i < C_NUM_SOURCES; i++) begin
            if (pps_sel == SEL_W'(i)) pps_edge = rise[i];
        end
    end

    // Phase error folded into (-F/2, F/2]
    always_comb begin
        if (fc_q >= lp_q) d = {1'b0, fc_q} - {1'b0, lp_q};
        else              d = {1'b0, fc_q} + F_W1 - {1'b0, lp_q};
        if (d <= HALF) e = $signed(d);
        else           e = $signed(d - F_W1);
    end

    assign is_match = (e == '0);
    assign is_adv   = (e < 0) && (e >= -WIN_S);
    assign is_late  = (e > 0) && (e <= WIN_S);
    assign in_win   = is_match || is_adv || is_late;

    assign dl_sum   = {1'b0, lp_q} + DL_OFF;
    assign deadline = (dl_sum >= F_W1) ? dl_sum - F_W1 : dl_sum;
    assign dl_hit   = ({1'b0, fc_q} == deadline);
    assign miss     = dl_hit && !edge_seen_q && !pps_edge;

    assign fc_d = (fc_q == W'(C_CLOCK_FREQUENCY - 1)) ? '0 : fc_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        lp_d        = lp_q;
        adv_d       = adv_q;
        late_d      = late_q;
        lock_d      = lock_q;
        miss_d      = miss_q;
        edge_seen_d = edge_seen_q;

        if (pps_edge)    edge_seen_d = 1'b1;
        else if (dl_hit) edge_seen_d = 1'b0;

        if (pps_edge) begin
            if (state_q == ST_NO_SIGNAL || !in_win) begin
                lp_d    = fc_q;
                adv_d   = '0;
                late_d  = '0;
                lock_d  = '0;
                miss_d  = '0;
                state_d = ST_ACQUIRE;
            end else begin
                if (is_match) begin
                    adv_d  = sat_dec(adv_q);
                    late_d = sat_dec(late_q);
                end else if (is_adv) begin
                    late_d = sat_dec(late_q);
                    if (&adv_q) begin
                        lp_d   = fc_q;
                        adv_d  = '0;
                        late_d = '0;
                    end else begin
                        adv_d = adv_q + 1'b1;
                    end
                end else begin
                    adv_d = sat_dec(adv_q);
                    if (&late_q) begin
                        lp_d   = fc_q;
                        adv_d  = '0;
                        late_d = '0;
                    end else begin
                        late_d = late_q + 1'b1;
                    end
                end
                case (state_q)
                    ST_ACQUIRE: begin
                        if (lock_q >= LK_W'(C_LOCK_COUNT - 1)) begin
                            lock_d  = LK_W'(C_LOCK_COUNT);
                            state_d = ST_LOCKED;
                        end else begin
                            lock_d = lock_q + 1'b1;
                        end
                    end
                    ST_HOLDOVER: begin
                        state_d = ST_LOCKED;
                        miss_d  = '0;
                    end
                    default: ;
                endcase
            end
        end else if (miss) begin
            case (state_q)
                ST_ACQUIRE: lock_d = '0;
                ST_LOCKED: begin
                    state_d = ST_HOLDOVER;
                    miss_d  = MS_W'(1);
                end
                ST_HOLDOVER: begin
                    miss_d = miss_q + 1'b1;
                    if (miss_q >= MS_W'(C_HOLDOVER_MAX)) state_d = ST_NO_SIGNAL;
                end
                default: ;
            endcase
        end

        // A new source invalidates filter history; a lock degrades to holdover
        if (sel_change) begin
            adv_d  = '0;
            late_d = '0;
            lock_d = '0;
            if (state_d == ST_LOCKED) begin
                state_d = ST_HOLDOVER;
                miss_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q        <= '0;
            lp_q        <= '0;
            adv_q       <= '0;
            late_q      <= '0;
            lock_q      <= '0;
            miss_q      <= '0;
            edge_seen_q <= 1'b0;
            state_q     <= ST_NO_SIGNAL;
            pps_out_q   <= 1'b0;
            phase_q     <= '0;
            err_q       <= '0;
            err_vld_q   <= 1'b0;
        end else begin
            fc_q        <= fc_d;
            lp_q        <= lp_d;
            adv_q       <= adv_d;
            late_q      <= late_d;
            lock_q      <= lock_d;
            miss_q      <= miss_d;
            edge_seen_q <= edge_seen_d;
            state_q     <= state_d;
            pps_out_q   <= (fc_q == lp_q);
            phase_q     <= lp_q;
            err_vld_q   <= pps_edge;
            if (pps_edge) err_q <= e;
        end
    end

    assign pps_out       = pps_out_q;
    assign pps_state     = state_q;
    assign pps_phase     = phase_q;
    assign pps_err       = err_q;
    assign pps_err_valid = err_vld_q;

endmodule
